mul_sequencer: RTL and testbench

//  Multicycle controller for LEGv8 MUL/UMULH/SMULH. Replaces the single-cycle combinational multiply with an iterative shift-add datapath.

---
 rtl/mul_sequencer_if.sv | 32 +++
 rtl/mul_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: operand/result handshake bundle between the EX stage
// (master) and the multicycle multiplier (slave).
//   start_valid/start_ready  operand handshake; op, a, b, rd_in qualify it
//   flush                    squash whatever the multiplier is doing
//   result_valid/ready       result handshake; result, rd_out qualify it
//   busy                     multiplier is not idle
interface mul_sequencer_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd_in;
    logic             flush;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             busy;

    modport master (
        output start_valid, op, a, b, rd_in, flush, result_ready,
        input  start_ready, result_valid, result, rd_out, busy
    );

    modport slave (
        input  start_valid, op, a, b, rd_in, flush, result_ready,
        output start_ready, result_valid, result, rd_out, busy
    );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier for LEGv8 MUL/UMULH/SMULH.
// Retires BITS_PER_CYCLE multiplier bits per RUN cycle into a 2*WIDTH
// accumulator; SMULH gets one extra SIGNFIX cycle that converts the unsigned
// high half into the signed high half.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    mul_sequencer_if slave: operand handshake (start_valid/ready,
//          op, a, b, rd_in), flush, result handshake (result_valid/ready,
//          result, rd_out) and busy
// op: 00 MUL (low half), 01 UMULH, 10 SMULH, 11 same as MUL.
// WIDTH must be a multiple of BITS_PER_CYCLE (1, 2 or 4).
module mul_sequencer #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           reset,
    mul_sequencer_if.slave bus
);
    localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGNFIX, DONE} state_e;
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_SMULH = 2'b10,
        OP_MUL2  = 2'b11
    } op_e;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [4:0]           tag_q, tag_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [4:0]           rd_out_q, rd_out_d;
    logic                 result_valid_q, result_valid_d;

    int unsigned               k;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [2*WIDTH-1:0]        a_ext;
    logic [2*WIDTH-1:0]        pp;
    logic [WIDTH-1:0]          hi_fix;

    // Partial product for the current multiplier slice, plus the signed
    // correction of the high half used by SMULH.
    always_comb begin
        k      = 32'(cnt_q) * BITS_PER_CYCLE;
        chunk  = BITS_PER_CYCLE'(b_q >> k);
        a_ext  = {{WIDTH{1'b0}}, a_q};
        pp     = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (chunk[i]) begin
                pp = pp + (a_ext << i);
            end
        end
        hi_fix = acc_q[2*WIDTH-1:WIDTH]
               - (a_q[WIDTH-1] ? b_q : '0)
               - (b_q[WIDTH-1] ? a_q : '0);
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        tag_d          = tag_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        rd_out_d       = rd_out_q;
        result_valid_d = result_valid_q;

        unique case (state_q)
            IDLE: begin
                // flush wins over a simultaneous start
                if (bus.start_valid && !bus.flush) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = op_e'(bus.op);
                    tag_d   = bus.rd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + (pp << k);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        if (op_q == OP_SMULH) begin
                            state_d = SIGNFIX;
                        end else begin
                            state_d        = DONE;
                            result_valid_d = 1'b1;
                            rd_out_d       = tag_q;
                            result_d       = (op_q == OP_UMULH) ? acc_d[2*WIDTH-1:WIDTH]
                                                                : acc_d[WIDTH-1:0];
                        end
                    end
                end
            end
            SIGNFIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d          = {hi_fix, acc_q[WIDTH-1:0]};
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    rd_out_d       = tag_q;
                    result_d       = hi_fix;
                end
            end
            DONE: begin
                // flush drops the result even if it is being accepted
                if (bus.flush || bus.result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_MUL;
            a_q            <= '0;
            b_q            <= '0;
            tag_q          <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            rd_out_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            tag_q          <= tag_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            rd_out_q       <= rd_out_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.start_ready  = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
endmodule

// File: tb/tb_mul_sequencer.sv
`timescale 1ns/1ps
module tb_mul_sequencer;
    localparam int unsigned W = 64;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // index 0: BITS_PER_CYCLE=1 unit, index 1: BITS_PER_CYCLE=4 unit
    logic [1:0]  sv, fl, rr, rr_mode, rr_force;
    logic [1:0]  op_s;
    logic [63:0] a_s, b_s;
    logic [4:0]  rd_s;

    logic [1:0]  sr, rv, bz;
    logic [63:0] res [2];
    logic [4:0]  rdo [2];

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    mul_sequencer_if #(.WIDTH(W)) bus1 ();
    mul_sequencer_if #(.WIDTH(W)) bus4 ();

    mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    assign bus1.start_valid  = sv[0];
    assign bus1.flush        = fl[0];
    assign bus1.result_ready = rr[0];
    assign bus1.op           = op_s;
    assign bus1.a            = a_s;
    assign bus1.b            = b_s;
    assign bus1.rd_in        = rd_s;
    assign bus4.start_valid  = sv[1];
    assign bus4.flush        = fl[1];
    assign bus4.result_ready = rr[1];
    assign bus4.op           = op_s;
    assign bus4.a            = a_s;
    assign bus4.b            = b_s;
    assign bus4.rd_in        = rd_s;

    assign sr     = {bus4.start_ready, bus1.start_ready};
    assign rv     = {bus4.result_valid, bus1.result_valid};
    assign bz     = {bus4.busy, bus1.busy};
    assign res[0] = bus1.result;
    assign res[1] = bus4.result;
    assign rdo[0] = bus1.rd_out;
    assign rdo[1] = bus4.rd_out;

    // Reference: full-width products computed directly.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0]        up;
        logic signed [127:0] sp;
        up = {64'd0, x} * {64'd0, y};
        sp = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
        case (o)
            2'b01:   return up[127:64];
            2'b10:   return sp[127:64];
            default: return up[63:0];
        endcase
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // result_ready driver: fixed per unit, or random backpressure
    always @(posedge clk) begin
        #4;
        for (int u = 0; u < 2; u++) begin
            rr[u] = rr_mode[u] ? ($urandom_range(0, 3) != 0) : rr_force[u];
        end
    end

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        int   sz;
        if (reset === 1'b0) begin
            for (int u = 0; u < 2; u++) begin
                if (rv[u] && rr[u] && !fl[u]) begin
                    sz = (u == 0) ? q0.size() : q1.size();
                    if (sz == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result_u%0d: got %h with no pending op", u, res[u]);
                    end else begin
                        if (u == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check($sformatf("result_u%0d", u), res[u], e.res);
                        check($sformatf("rd_out_u%0d", u), 64'(rdo[u]), 64'(e.rd));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int u, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] t, input bit push, output int waits);
        exp_t e;
        op_s  = o;
        a_s   = x;
        b_s   = y;
        rd_s  = t;
        sv[u] = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!(sr[u] && !fl[u]) && waits < 500) begin
            @(negedge clk);
            waits++;
        end
        if (!(sr[u] && !fl[u])) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_u%0d: start_ready=%b after %0d cycles, required 1", u, sr[u], waits);
        end else if (push) begin
            e.res = model(o, x, y);
            e.rd  = t;
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        tick();
        sv[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int n;
        n = 0;
        while (!sr[u] && n < 500) begin
            tick();
            n++;
        end
        if (!sr[u]) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout_u%0d: start_ready=%b, required 1", u, sr[u]);
        end
    endtask

    task automatic wait_valid(input int u);
        int n;
        n = 0;
        while (!rv[u] && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic run_lat(input int u, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                           input logic [4:0] t, input int exp_lat);
        int w;
        int lat;
        issue(u, o, x, y, t, 1'b1, w);
        check($sformatf("busy_after_accept_u%0d", u), 64'(bz[u]), 64'd1);
        lat = 0;
        while (!rv[u] && lat < 300) begin
            tick();
            lat++;
        end
        check($sformatf("latency_u%0d_op%0d", u, o), 64'(lat), 64'(exp_lat));
        wait_idle(u);
    endtask

    task automatic check_reset_state(input int u, input string tag);
        check($sformatf("%s_result_valid_u%0d", tag, u), 64'(rv[u]), 64'd0);
        check($sformatf("%s_busy_u%0d", tag, u), 64'(bz[u]), 64'd0);
        check($sformatf("%s_start_ready_u%0d", tag, u), 64'(sr[u]), 64'd1);
        check($sformatf("%s_result_u%0d", tag, u), res[u], 64'd0);
        check($sformatf("%s_rd_out_u%0d", tag, u), 64'(rdo[u]), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          w;
        int          n;
        int          rises;
        logic [63:0] held_res;
        logic [4:0]  held_rd;

        reset    = 1'b1;
        sv       = '0;
        fl       = '0;
        rr_mode  = '0;
        rr_force = 2'b11;
        op_s     = '0;
        a_s      = '0;
        b_s      = '0;
        rd_s     = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_state(0, "reset");
        check_reset_state(1, "reset");
        reset = 1'b0;
        tick();

        // Directed, one bit per cycle
        run_lat(0, 2'b00, 64'd3, 64'd5, 5'd1, 64);
        run_lat(0, 2'b01, '1, '1, 5'd2, 64);
        run_lat(0, 2'b00, '1, '1, 5'd3, 64);
        run_lat(0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 5'd4, 64);
        run_lat(0, 2'b10, '1, 64'd2, 5'd5, 65);
        run_lat(0, 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6, 65);

        // Backpressure in DONE
        rr_force[0] = 1'b0;
        issue(0, 2'b10, 64'hDEAD_BEEF_0000_1234, 64'hF000_0000_0000_0007, 5'd7, 1'b1, w);
        wait_valid(0);
        check("bp_valid", 64'(rv[0]), 64'd1);
        held_res = res[0];
        held_rd  = rdo[0];
        a_s      = ~a_s;
        sv[0]    = 1'b1;
        repeat (10) begin
            tick();
            check("bp_result_stable", res[0], held_res);
            check("bp_rd_stable", 64'(rdo[0]), 64'(held_rd));
            check("bp_start_ready", 64'(sr[0]), 64'd0);
            check("bp_valid_held", 64'(rv[0]), 64'd1);
        end
        sv[0]       = 1'b0;
        rr_force[0] = 1'b1;
        tick();
        check("bp_idle_after_handshake", 64'(sr[0]), 64'd1);
        check("bp_valid_dropped", 64'(rv[0]), 64'd0);
        issue(0, 2'b01, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003, 5'd8, 1'b1, w);
        check("bp_next_accept_waits", 64'(w), 64'd0);
        wait_valid(0);
        wait_idle(0);

        // flush during RUN
        held_res = res[0];
        held_rd  = rdo[0];
        issue(0, 2'b00, 64'h1111, 64'h2222, 5'd9, 1'b0, w);
        repeat (19) tick();
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        check("flush_run_start_ready", 64'(sr[0]), 64'd1);
        check("flush_run_busy", 64'(bz[0]), 64'd0);
        check("flush_run_result", res[0], held_res);
        check("flush_run_rd", 64'(rdo[0]), 64'(held_rd));
        rises = 0;
        repeat (80) begin
            tick();
            if (rv[0]) rises++;
        end
        check("flush_run_no_valid", 64'(rises), 64'd0);

        // reset during RUN
        issue(0, 2'b00, 64'h3333, 64'h4444, 5'd10, 1'b0, w);
        repeat (20) tick();
        reset = 1'b1;
        #1;
        check_reset_state(0, "midreset");
        tick();
        reset = 1'b0;
        tick();

        // flush in IDLE beats start_valid
        fl[0] = 1'b1;
        sv[0] = 1'b1;
        tick();
        tick();
        check("flush_idle_busy", 64'(bz[0]), 64'd0);
        check("flush_idle_start_ready", 64'(sr[0]), 64'd1);
        fl[0] = 1'b0;
        sv[0] = 1'b0;

        // flush in DONE drops the result despite result_ready
        rr_force[0] = 1'b0;
        issue(0, 2'b00, 64'd7, 64'd9, 5'd11, 1'b0, w);
        wait_valid(0);
        check("flush_done_valid", 64'(rv[0]), 64'd1);
        fl[0]       = 1'b1;
        rr_force[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        check("flush_done_dropped", 64'(rv[0]), 64'd0);
        check("flush_done_idle", 64'(sr[0]), 64'd1);

        // Four bits per cycle
        run_lat(1, 2'b00, 64'h1_2345_6789, 64'h1000, 5'd12, 16);
        run_lat(1, 2'b10, '1, 64'd2, 5'd13, 17);

        // Random vectors under random backpressure
        rr_mode = 2'b11;
        for (int i = 0; i < 1000; i++) begin
            issue(1, 2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom()), 1'b1, w);
        end
        for (int i = 0; i < 40; i++) begin
            issue(0, 2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom()), 1'b1, w);
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
